// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_arbiter
//  Purpose  : Round-robin arbiter that shares one combinational
//             single-precision FP adder among NUM_REQ requesters. The winning
//             operands are registered, the adder is driven for one cycle, and
//             the captured sum is returned with the requester ID over a
//             valid/ready response channel. One operation in flight at a time.
//  Options  : FP_ARB_SUB_EN - adds req_sub; a set bit flips the sign of
//             operand B so the adder computes A-B.
//  Ports    : clk, rst_n          clock / async active-low reset
//             req_valid/ready    per-requester handshake (ready is one-hot)
//             req_a, req_b       packed operands, 32 bits per requester
//             req_sub            per-requester subtract (FP_ARB_SUB_EN only)
//             add_a/add_b/add_en shared adder operands and enable
//             add_o              shared adder sum (combinational)
//             rsp_valid/ready    response handshake
//             rsp_data, rsp_id   sum bit pattern and owning requester
//             busy               high while an operation is outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
`ifdef FP_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]     req_sub,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    output logic                   add_en,
    input  logic [31:0]            add_o,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    localparam logic [ID_W-1:0] c_LAST_IDX = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   c_NUM_REQ  = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [31:0]         r_add_a;
    logic [31:0]         r_add_b;
    logic                r_add_en;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_busy;

    logic [31:0]         w_a [NUM_REQ];
    logic [31:0]         w_b [NUM_REQ];
    logic [ID_W-1:0]     w_start;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]  w_rot;
    logic [ID_W-1:0]     w_off;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_winner;
    logic                w_take;
    logic [31:0]         w_b_eff;

    // Unpack the flat operand buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[32*gi +: 32];
            assign w_b[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // Round-robin search: rotate the request vector so the bit after the
    // last winner sits at position 0, pick the lowest set bit, then map the
    // offset back to an absolute index.
    assign w_start = (r_rr_ptr == c_LAST_IDX) ? '0 : r_rr_ptr + 1'b1;
    assign w_dbl   = {req_valid, req_valid};
    assign w_rot   = w_dbl[w_start +: NUM_REQ];

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    assign w_sum    = {1'b0, w_start} + {1'b0, w_off};
    assign w_winner = (w_sum >= c_NUM_REQ) ? ID_W'(w_sum - c_NUM_REQ)
                                           : w_sum[ID_W-1:0];

    // Grants only in IDLE and never while reset is applied.
    assign w_take    = rst_n && (r_state == ST_IDLE) && (|req_valid);
    assign req_ready = w_take ? (NUM_REQ'(1) << w_winner) : '0;

    // Subtraction is folded in at transfer time so add_b comes straight
    // from a register during EXEC.
`ifdef FP_ARB_SUB_EN
    assign w_b_eff = req_sub[w_winner] ? {~w_b[w_winner][31], w_b[w_winner][30:0]}
                                       : w_b[w_winner];
`else
    assign w_b_eff = w_b[w_winner];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= c_LAST_IDX;
            r_id        <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_add_a  <= w_a[w_winner];
                        r_add_b  <= w_b_eff;
                        r_id     <= w_winner;
                        r_rr_ptr <= w_winner;
                        r_add_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The only cycle in which the adder output is sampled.
                    r_rsp_data  <= add_o;
                    r_rsp_id    <= r_id;
                    r_add_en    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_add_en    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_en    = r_add_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_add_arbiter
//  Purpose  : Self-checking bench for fp_add_arbiter. A behavioural model
//             predicts grants and the busy/EXEC/RESP timeline; responses are
//             queued at accept and checked by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic                  add_en;
    logic [31:0]           add_o;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    always #5 clk = ~clk;

    // ---------------- requester-side state ----------------
    logic [31:0] ra   [NUM_REQ];
    logic [31:0] rb   [NUM_REQ];
    logic        rsub [NUM_REQ];
    logic        rv   [NUM_REQ];
    logic [31:0] rovr [NUM_REQ];
    logic        rhas [NUM_REQ];
    logic        granted [NUM_REQ];

    always_comb begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = rv[i];
            req_a[32*i +: 32]  = ra[i];
            req_b[32*i +: 32]  = rb[i];
            req_sub[i]         = rsub[i];
        end
    end

    // ---------------- shared adder model ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(int'(f[30:23]) + 896);
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = int'(d[62:52]) - 896;
        m = {1'b0, d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Garbage when disabled so sampling outside EXEC is visible.
    assign add_o = add_en ? fp_add(add_a, add_b) : 32'hDEAD_BEEF;

    fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef FP_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_o     (add_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
    } rsp_t;

    rsp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          last_win = NUM_REQ - 1;
    int          stage = 0;          // 0 idle, 1 exec, 2 resp
    logic [31:0] x_a, x_b;
    int          cyc = 0;
    int          rdy_mode = 0;       // 0 always ready, 1 random, 2 stalled
    bit          gen_on = 1'b0;
    bit          hold = 1'b0;
    int          win_log[$];
    int          win_cyc[$];
    int          exp_rr[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] b_eff(input int i);
`ifdef FP_ARB_SUB_EN
        if (rsub[i]) return {~rb[i][31], rb[i][30:0]};
`endif
        return rb[i];
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] f;
        f[31]    = 1'($urandom_range(0, 1));
        f[30:23] = 8'($urandom_range(120, 134));
        f[22:0]  = 23'($urandom);
        return f;
    endfunction

    // Called at a falling edge with inputs already set for the coming cycle;
    // returns at the next falling edge.
    task automatic step();
        int          pick;
        logic [31:0] ev;
        rsp_t        e;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
        #1;
        pick = -1;
        if (stage == 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (pick < 0 && rv[(last_win + k) % NUM_REQ]) pick = (last_win + k) % NUM_REQ;
            end
        end
        check("req_ready", 32'(req_ready), (pick < 0) ? 32'd0 : (32'd1 << pick));
        check("busy",      32'(busy),      32'(stage != 0));
        check("add_en",    32'(add_en),    32'(stage == 1));
        check("rsp_valid", 32'(rsp_valid), 32'(stage == 2));
        if (stage == 1) begin
            check("add_a", add_a, x_a);
            check("add_b", add_b, x_b);
        end
        if (stage == 0 && pick >= 0) begin
            x_a = ra[pick];
            x_b = b_eff(pick);
            ev  = rhas[pick] ? rovr[pick] : fp_add(x_a, x_b);
            e.data = ev;
            e.id   = ID_W'(pick);
            exp_q.push_back(e);
            last_win = pick;
            win_log.push_back(pick);
            win_cyc.push_back(cyc);
            granted[pick] = 1'b1;
            stage = 1;
        end else if (stage == 1) begin
            stage = 2;
        end else if (stage == 2 && rsp_ready) begin
            stage = 0;
        end
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted[i]) begin
                granted[i] = 1'b0;
                if (!hold) begin
                    rv[i]   = 1'b0;
                    rhas[i] = 1'b0;
                end
            end else if (gen_on && rv[i] && $urandom_range(0, 31) == 0) begin
                rv[i] = 1'b0;   // requester withdraws before being granted
            end else if (gen_on && !rv[i] && $urandom_range(0, 3) == 0) begin
                ra[i]   = rand_fp();
                rb[i]   = ($urandom_range(0, 7) == 0) ? {~ra[i][31], ra[i][30:0]} : rand_fp();
                rsub[i] = 1'($urandom_range(0, 1));
                rhas[i] = 1'b0;
                rv[i]   = 1'b1;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic has, input logic [31:0] ovr);
        ra[i] = a; rb[i] = b; rsub[i] = s; rhas[i] = has; rovr[i] = ovr; rv[i] = 1'b1;
    endtask

    // ---------------- response monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected @cyc %0d: got id %0d data %h expected no response",
                             cyc, rsp_id, rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = '0; rb[i] = '0; rsub[i] = 1'b0; rv[i] = 1'b0;
            rovr[i] = '0; rhas[i] = 1'b0; granted[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_add_en",    32'(add_en),    32'd0);
        check("rst_add_a",     add_a,          32'd0);
        check("rst_add_b",     add_b,          32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;

        // 1.0 + 2.0 = 3.0 from requester 0
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4040_0000);
        repeat (5) step();
        // cancellation from requester 2
        set_req(2, 32'h3FC0_0000, 32'hBFC0_0000, 1'b0, 1'b1, 32'h0000_0000);
        repeat (5) step();
        // requester 3 moves the pointer so the rotation starts at 0
        set_req(3, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        repeat (5) step();

        // round robin with all requesters held valid
        hold = 1'b1;
        set_req(0, 32'h3F80_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h3FC0_0000);
        set_req(1, 32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h4020_0000);
        set_req(2, 32'h4040_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h4060_0000);
        set_req(3, 32'h4080_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h4090_0000);
        base = win_log.size();
        repeat (15) step();
        hold = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rv[i] = 1'b0; rhas[i] = 1'b0;
        end
        check("rr_count", 32'(win_log.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < win_log.size()) begin
                check("rr_order", 32'(win_log[base + i]), 32'(exp_rr[i]));
                if (i > 0) check("rr_gap", 32'(win_cyc[base + i] - win_cyc[base + i - 1]), 32'd3);
            end
        end
        repeat (3) step();

        // backpressure: response held for several cycles, second requester waits
        rdy_mode = 2;
        set_req(1, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        set_req(3, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        repeat (7) step();
        rdy_mode = 0;
        repeat (8) step();

        // reset while in EXEC
        set_req(2, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        step();
        check("exec_before_reset", 32'(stage), 32'd1);
        #3;
        rv[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_add_en",    32'(add_en),    32'd0);
        check("mid_rst_add_a",     add_a,          32'd0);
        check("mid_rst_add_b",     add_b,          32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        stage = 0;
        last_win = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rv[i] = 1'b0; rhas[i] = 1'b0; granted[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        set_req(3, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        set_req(0, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'd0);
        base = win_log.size();
        step();
        check("post_rst_first_grant", (win_log.size() > base) ? 32'(win_log[base]) : 32'hFFFF_FFFF, 32'd0);
        repeat (8) step();

`ifdef FP_ARB_SUB_EN
        // 3.0 - 1.0 = 2.0 from requester 1
        set_req(1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h4000_0000);
        step();
        check("sub_add_b", x_b, 32'hBF80_0000);
        repeat (4) step();
`endif

        // randomized traffic with random backpressure
        gen_on = 1'b1;
        rdy_mode = 1;
        repeat (1500) step();
        gen_on = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!granted[i]) rv[i] = 1'b0;
        end
        rdy_mode = 0;
        repeat (10) step();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
